// File: rtl/systolic_col_ctrl_if.sv
// systolic_col_ctrl_if: activation/weight buffer read bus.
// master: controller drives strobes and addresses; slave: buffer side.
interface systolic_col_ctrl_if #(
  parameter int CH_W = 12
);

  logic            dat_rd_en;
  logic            wt_rd_en;
  logic [CH_W-1:0] dat_rd_addr;
  logic [CH_W-1:0] wt_rd_addr;

  modport master (
    output dat_rd_en,
    output wt_rd_en,
    output dat_rd_addr,
    output wt_rd_addr
  );

  modport slave (
    input dat_rd_en,
    input wt_rd_en,
    input dat_rd_addr,
    input wt_rd_addr
  );

endinterface

// File: rtl/systolic_col_ctrl.sv
// systolic_col_ctrl: per-job sequencer for one systolic PE column.
// Ports: clk, rst (sync, active-high); start + cfg_* job setup
// (tin_factor, ch_grp, pix, dat/wt base); out_ready back-pressure;
// rd = buffer read bus (master); tin_factor to PEs; acc_clr/acc_vld/
// out_vld accumulator controls; busy/done/err status; perf_stall_cnt.
// Optional stall counter enabled by defining SYSTOLIC_CTRL_PERF_EN.
module systolic_col_ctrl #(
  parameter int CH_W     = 12,
  parameter int PIX_W    = 16,
  parameter int PIPE_LAT = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            cfg_tin_factor,
  input  logic [CH_W-1:0]       cfg_ch_grp,
  input  logic [PIX_W-1:0]      cfg_pix,
  input  logic [CH_W-1:0]       cfg_dat_base,
  input  logic [CH_W-1:0]       cfg_wt_base,
  input  logic                  out_ready,
  systolic_col_ctrl_if.master   rd,
  output logic [3:0]            tin_factor,
  output logic                  acc_clr,
  output logic                  acc_vld,
  output logic                  out_vld,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           perf_stall_cnt
);

  localparam int DW =
    (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST =
    DW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RDY,
    DRAIN,
    FIN
  } state_t;

  state_t st;
  state_t nxt;

  logic [CH_W-1:0]     ch_grp_r;
  logic [CH_W-1:0]     dat_base_r;
  logic [CH_W-1:0]     wt_base_r;
  logic [CH_W-1:0]     g_cnt;
  logic [CH_W-1:0]     iss_cnt;
  logic [PIX_W-1:0]    pix_r;
  logic [PIX_W-1:0]    pix_cnt;
  logic [DW-1:0]       drain_cnt;
  logic [PIPE_LAT-1:0] vld_d;
  logic [PIPE_LAT-1:0] clr_d;
  logic [PIPE_LAT-1:0] lst_d;

  logic cfg_ok;
  logic accept;
  logic reject;
  logic issue;
  logic g_last;
  logic p_last;

  assign cfg_ok =
    (cfg_ch_grp != '0) &&
    (cfg_pix != '0) &&
    (cfg_tin_factor inside
      {4'd1, 4'd2, 4'd4, 4'd8});

  assign g_last = (g_cnt == ch_grp_r - 1'b1);
  assign p_last = (pix_cnt == pix_r - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
    end else begin
      st <= nxt;
    end
  end

  // out_ready only matters at pixel boundaries, so a
  // started pixel always issues back-to-back.
  always_comb begin
    nxt    = st;
    accept = 1'b0;
    reject = 1'b0;
    issue  = 1'b0;
    unique case (st)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            accept = 1'b1;
            nxt    = WAIT_RDY;
          end else begin
            reject = 1'b1;
          end
        end
      end
      WAIT_RDY: begin
        if (out_ready) begin
          nxt = ISSUE;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (g_last) begin
          if (p_last) begin
            nxt = DRAIN;
          end else if (!out_ready) begin
            nxt = WAIT_RDY;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          nxt = FIN;
        end
      end
      FIN: begin
        nxt = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_grp_r   <= '0;
      dat_base_r <= '0;
      wt_base_r  <= '0;
      pix_r      <= '0;
      g_cnt      <= '0;
      iss_cnt    <= '0;
      pix_cnt    <= '0;
      drain_cnt  <= '0;
      tin_factor <= 4'd1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (accept) begin
        ch_grp_r   <= cfg_ch_grp;
        dat_base_r <= cfg_dat_base;
        wt_base_r  <= cfg_wt_base;
        pix_r      <= cfg_pix;
        tin_factor <= cfg_tin_factor;
        g_cnt      <= '0;
        iss_cnt    <= '0;
        pix_cnt    <= '0;
      end
      if (issue) begin
        iss_cnt <= iss_cnt + 1'b1;
        if (g_last) begin
          g_cnt   <= '0;
          pix_cnt <= pix_cnt + 1'b1;
        end else begin
          g_cnt <= g_cnt + 1'b1;
        end
      end
      if (st == DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
      end else begin
        drain_cnt <= '0;
      end
      // Status pulses are registered: one cycle after
      // the FIN state / the rejected start.
      done <= (st == FIN);
      err  <= reject;
    end
  end

  // Strobe delay lines model the PE column latency;
  // clearing them on rst kills in-flight results.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_d <= '0;
      clr_d <= '0;
      lst_d <= '0;
    end else begin
      vld_d[0] <= issue;
      clr_d[0] <= issue && (g_cnt == '0);
      lst_d[0] <= issue && g_last;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_d[i] <= vld_d[i-1];
        clr_d[i] <= clr_d[i-1];
        lst_d[i] <= lst_d[i-1];
      end
    end
  end

  assign rd.dat_rd_en = issue;
  assign rd.wt_rd_en  = issue;
  assign rd.dat_rd_addr =
    issue ? dat_base_r + iss_cnt : '0;
  assign rd.wt_rd_addr =
    issue ? wt_base_r + g_cnt : '0;

  assign acc_vld = vld_d[PIPE_LAT-1];
  assign acc_clr = clr_d[PIPE_LAT-1];
  assign out_vld = lst_d[PIPE_LAT-1];

  assign busy =
    (st == WAIT_RDY) ||
    (st == ISSUE) ||
    (st == DRAIN);

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if ((st == WAIT_RDY) && !out_ready &&
                 (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_systolic_col_ctrl.sv
// tb_systolic_col_ctrl: table vectors, hand sequences and random jobs
// checked cycle by cycle against an event-list model of a job.
`timescale 1ns/1ps
module tb_systolic_col_ctrl;

  localparam int L    = 6;
  localparam int MAXC = 400;
`ifdef SYSTOLIC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  cfg_tin_factor;
  logic [11:0] cfg_ch_grp;
  logic [15:0] cfg_pix;
  logic [11:0] cfg_dat_base;
  logic [11:0] cfg_wt_base;
  logic        out_ready;
  logic [3:0]  tin_factor;
  logic        acc_clr;
  logic        acc_vld;
  logic        out_vld;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] perf_stall_cnt;

  systolic_col_ctrl_if #(.CH_W(12)) bus ();

  systolic_col_ctrl #(
    .CH_W(12),
    .PIX_W(16),
    .PIPE_LAT(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cfg_tin_factor(cfg_tin_factor),
    .cfg_ch_grp(cfg_ch_grp),
    .cfg_pix(cfg_pix),
    .cfg_dat_base(cfg_dat_base),
    .cfg_wt_base(cfg_wt_base),
    .out_ready(out_ready),
    .rd(bus),
    .tin_factor(tin_factor),
    .acc_clr(acc_clr),
    .acc_vld(acc_vld),
    .out_vld(out_vld),
    .busy(busy),
    .done(done),
    .err(err),
    .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit          rdy    [MAXC];
  bit          e_rd   [MAXC];
  bit          e_vld  [MAXC];
  bit          e_clr  [MAXC];
  bit          e_ov   [MAXC];
  bit          e_busy [MAXC];
  bit          e_done [MAXC];
  bit          e_err  [MAXC];
  logic [11:0] e_wt   [MAXC];
  logic [11:0] e_dat  [MAXC];

  int          m_done;
  int          m_last;
  int          m_stall;
  logic [3:0]  tf_m;
  logic [31:0] perf_m;
  int          first_rd;
  int          done_c;
  int          done_n;
  int          err_c;
  int          ov_q[$];

  typedef struct {
    logic [3:0]  tf;
    int          ch;
    int          pix;
    logic [11:0] db;
    logic [11:0] wb;
    int          exp_err;
    int          exp_done;
  } vec_t;

  vec_t tbl[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h",
               nm, act, exp);
    end
  endtask

  // Job as event lists: pixel p issues ch reads in a row once
  // out_ready was seen in WAIT_RDY (or at the previous pixel end);
  // each read yields its accumulator strobes L cycles later.
  task automatic build_model(input int ch, input int pix,
                             input logic [11:0] db,
                             input logic [11:0] wb,
                             input bit ok);
    int t;
    int s;
    int e;
    logic [11:0] n;
    for (int c = 0; c < MAXC; c++) begin
      e_rd[c] = 0; e_vld[c] = 0; e_clr[c] = 0;
      e_ov[c] = 0; e_busy[c] = 0; e_done[c] = 0;
      e_err[c] = 0; e_wt[c] = '0; e_dat[c] = '0;
    end
    m_stall = 0;
    m_done = -1;
    if (!ok) begin
      e_err[1] = 1'b1;
      m_last = 4;
      return;
    end
    t = 1;
    e = 0;
    n = '0;
    for (int p = 0; p < pix; p++) begin
      while (!rdy[t]) begin
        m_stall++;
        t++;
      end
      s = t + 1;
      for (int g = 0; g < ch; g++) begin
        e_rd[s+g]    = 1'b1;
        e_wt[s+g]    = wb + 12'(g);
        e_dat[s+g]   = db + n;
        n            = n + 12'd1;
        e_vld[s+g+L] = 1'b1;
        e_clr[s+g+L] = (g == 0);
        e_ov[s+g+L]  = (g == ch - 1);
      end
      e = s + ch - 1;
      t = rdy[e] ? e : e + 1;
    end
    m_done = e + L + 2;
    e_done[m_done] = 1'b1;
    for (int c = 1; c < m_done - 1; c++) begin
      e_busy[c] = 1'b1;
    end
    m_last = m_done + 2;
  endtask

  task automatic cmp(input int c);
    string s;
    s = $sformatf("cyc%0d", c);
    chk({s, ".dat_rd_en"}, 32'(bus.dat_rd_en), 32'(e_rd[c]));
    chk({s, ".wt_rd_en"}, 32'(bus.wt_rd_en), 32'(e_rd[c]));
    if (e_rd[c]) begin
      chk({s, ".dat_addr"}, 32'(bus.dat_rd_addr), 32'(e_dat[c]));
      chk({s, ".wt_addr"}, 32'(bus.wt_rd_addr), 32'(e_wt[c]));
    end
    chk({s, ".acc_vld"}, 32'(acc_vld), 32'(e_vld[c]));
    chk({s, ".acc_clr"}, 32'(acc_clr), 32'(e_clr[c]));
    chk({s, ".out_vld"}, 32'(out_vld), 32'(e_ov[c]));
    chk({s, ".busy"}, 32'(busy), 32'(e_busy[c]));
    chk({s, ".done"}, 32'(done), 32'(e_done[c]));
    chk({s, ".err"}, 32'(err), 32'(e_err[c]));
    chk({s, ".tin_factor"}, 32'(tin_factor), 32'(tf_m));
  endtask

  // Called in an IDLE cycle (cycle 0 of the job).
  task automatic run_job(input logic [3:0] tf, input int ch,
                         input int pix, input logic [11:0] db,
                         input logic [11:0] wb, input bit noisy);
    bit ok;
    ok = (tf == 4'd1 || tf == 4'd2 || tf == 4'd4 ||
          tf == 4'd8) && ch > 0 && pix > 0;
    build_model(ch, pix, db, wb, ok);
    if (ok) begin
      tf_m   = tf;
      perf_m = PERF ? 32'(m_stall) : 32'd0;
    end
    cfg_tin_factor = tf;
    cfg_ch_grp     = 12'(ch);
    cfg_pix        = 16'(pix);
    cfg_dat_base   = db;
    cfg_wt_base    = wb;
    start          = 1'b1;
    out_ready      = rdy[0];
    first_rd = -1; done_c = -1; done_n = 0; err_c = -1;
    ov_q.delete();
    for (int c = 1; c <= m_last; c++) begin
      tick;
      if (noisy) begin
        cfg_tin_factor = 4'($urandom);
        cfg_ch_grp     = 12'($urandom);
        cfg_pix        = 16'($urandom);
        cfg_dat_base   = 12'($urandom);
        cfg_wt_base    = 12'($urandom);
      end
      start = noisy && ok && (c < m_done) &&
              ($urandom_range(0, 2) == 0);
      out_ready = rdy[c];
      if (bus.dat_rd_en === 1'b1 && first_rd < 0) first_rd = c;
      if (done === 1'b1) begin
        done_c = c;
        done_n++;
      end
      if (err === 1'b1) err_c = c;
      if (out_vld === 1'b1) ov_q.push_back(c);
      cmp(c);
    end
    start = 1'b0;
    chk("perf_stall_cnt", perf_stall_cnt, perf_m);
  endtask

  task automatic all_ready;
    for (int i = 0; i < MAXC; i++) rdy[i] = 1'b1;
  endtask

  initial begin
    logic [3:0] tfs[4];
    logic [3:0] bad[4];
    logic [3:0] tf;
    int ch;
    int pix;
    tfs = '{4'd1, 4'd2, 4'd4, 4'd8};
    bad = '{4'd0, 4'd3, 4'd6, 4'd12};

    tbl[0] = '{4'd1, 3, 2, 12'd0, 12'd0, -1, 15};
    tbl[1] = '{4'd8, 4, 1, 12'd4094, 12'd5, -1, 13};
    tbl[2] = '{4'd3, 3, 2, 12'd0, 12'd0, 1, -1};
    tbl[3] = '{4'd2, 0, 2, 12'd1, 12'd2, 1, -1};
    tbl[4] = '{4'd4, 2, 0, 12'd1, 12'd2, 1, -1};
    tbl[5] = '{4'd2, 1, 1, 12'd7, 12'd9, -1, 10};
    tbl[6] = '{4'd0, 1, 1, 12'd7, 12'd9, 1, -1};
    tbl[7] = '{4'd4, 2, 3, 12'd100, 12'd4095, -1, 15};

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    cfg_tin_factor = 4'd0; cfg_ch_grp = '0; cfg_pix = '0;
    cfg_dat_base = '0; cfg_wt_base = '0;
    tf_m = 4'd1; perf_m = '0;
    repeat (3) tick;
    rst = 1'b0;
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.err", 32'(err), 32'd0);
    chk("reset.rd_en", 32'(bus.dat_rd_en), 32'd0);
    chk("reset.acc_vld", 32'(acc_vld), 32'd0);
    chk("reset.tin_factor", 32'(tin_factor), 32'd1);
    chk("reset.perf", perf_stall_cnt, 32'd0);
    tick;

    all_ready();
    for (int i = 0; i < 8; i++) begin
      run_job(tbl[i].tf, tbl[i].ch, tbl[i].pix,
              tbl[i].db, tbl[i].wb, 1'b0);
      chk($sformatf("tbl%0d.err_cycle", i), err_c, tbl[i].exp_err);
      chk($sformatf("tbl%0d.done_cycle", i), done_c, tbl[i].exp_done);
    end

    // Reference job with no back-pressure.
    all_ready();
    run_job(4'd1, 3, 2, 12'd0, 12'd0, 1'b0);
    chk("ref.first_rd", first_rd, 2);
    chk("ref.out_vld_n", ov_q.size(), 2);
    if (ov_q.size() == 2) begin
      chk("ref.out_vld0", ov_q[0], 10);
      chk("ref.out_vld1", ov_q[1], 13);
    end
    chk("ref.done", done_c, 15);

    // Same job held off for cycles 0..9.
    all_ready();
    for (int i = 0; i < 10; i++) rdy[i] = 1'b0;
    run_job(4'd1, 3, 2, 12'd0, 12'd0, 1'b0);
    chk("stall.first_rd", first_rd, 11);
    chk("stall.perf", perf_stall_cnt, PERF ? 32'd9 : 32'd0);

    // Start re-pulsed with junk cfg throughout the job.
    all_ready();
    run_job(4'd2, 3, 3, 12'd50, 12'd60, 1'b1);
    chk("restart.done_n", done_n, 1);

    // Reset two cycles after the first read.
    cfg_tin_factor = 4'd4; cfg_ch_grp = 12'd3; cfg_pix = 16'd2;
    cfg_dat_base = 12'd0; cfg_wt_base = 12'd0;
    start = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick;
      start = 1'b0;
    end
    chk("abort.pre_rd", 32'(bus.dat_rd_en), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tf_m = 4'd1;
    perf_m = '0;
    chk("abort.perf", perf_stall_cnt, 32'd0);
    for (int c = 5; c < 25; c++) begin
      chk($sformatf("abort.c%0d.outs", c),
          {24'd0, bus.dat_rd_en, bus.wt_rd_en, acc_clr,
           acc_vld, out_vld, busy, done, err}, 32'd0);
      chk($sformatf("abort.c%0d.tf", c), 32'(tin_factor), 32'd1);
      tick;
    end

    // Random jobs, random back-pressure and re-starts.
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < MAXC; i++) begin
        rdy[i] = (i >= 150) || ($urandom_range(0, 9) < 7);
      end
      tf  = ($urandom_range(0, 7) == 0) ?
            bad[$urandom_range(0, 3)] : tfs[$urandom_range(0, 3)];
      ch  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      pix = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      run_job(tf, ch, pix, 12'($urandom), 12'($urandom),
              1'($urandom_range(0, 1)));
      if (m_done > 0) chk($sformatf("rnd%0d.done_n", j), done_n, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
